// File: rtl/axi_i2s_cfg_sequencer_if.sv
// rtl/axi_i2s_cfg_sequencer_if.sv - AXI4-Lite bus bundle between the config sequencer and the I2S core
//
// Purpose: groups the five AXI4-Lite channels used by the sequencer.
// Ports (signals):
//   AW: AWADDR, AWPROT, AWVALID (master out), AWREADY (slave out)
//   W : WDATA, WSTRB, WVALID (master out), WREADY (slave out)
//   B : BRESP, BVALID (slave out), BREADY (master out)
//   AR: ARADDR, ARPROT, ARVALID (master out), ARREADY (slave out)
//   R : RDATA, RRESP, RVALID (slave out), RREADY (master out)
interface axi_i2s_cfg_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_i2s_cfg_sequencer.sv
// rtl/axi_i2s_cfg_sequencer.sv - table-driven AXI4-Lite register configuration sequencer
//
// Purpose: walks C_NUM_ENTRIES (offset, data, mask) table entries, writes each to
// C_BASE_ADDR + offset, optionally reads it back and compares under the mask, and
// reports sticky done, or sticky error with a code and the failing table index.
// Ports:
//   ACLK, ARESET       clock, asynchronous active-high reset
//   start              single-cycle pulse; ignored while busy
//   busy/done/error    status (done and error are sticky until the next start)
//   err_code           01 non-OKAY response, 10 readback mismatch, 11 timeout
//   err_idx            table index of the failing entry
//   tbl_idx            table read index; tbl_offset/tbl_wdata/tbl_mask answer it
//   M_AXI              AXI4-Lite master bus
module axi_i2s_cfg_sequencer #(
    parameter int                      C_ADDR_WIDTH  = 32,
    parameter int                      C_DATA_WIDTH  = 32,
    parameter int                      C_NUM_ENTRIES = 4,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR   = '0,
    parameter int                      C_VERIFY      = 1,
    parameter int                      C_TIMEOUT     = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [7:0]              err_idx,
    output logic [7:0]              tbl_idx,
    input  logic [C_ADDR_WIDTH-1:0] tbl_offset,
    input  logic [C_DATA_WIDTH-1:0] tbl_wdata,
    input  logic [C_DATA_WIDTH-1:0] tbl_mask,
    axi_i2s_cfg_sequencer_if.master M_AXI
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_BRESP = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;

    localparam int              TW       = (C_TIMEOUT > 255) ? $clog2(C_TIMEOUT + 1) : 8;
    localparam logic [TW-1:0]   TMO_LAST = TW'(C_TIMEOUT - 1);
    localparam logic [7:0]      LAST_IDX = 8'(C_NUM_ENTRIES - 1);

    localparam logic [1:0] E_RESP     = 2'b01;
    localparam logic [1:0] E_MISMATCH = 2'b10;
    localparam logic [1:0] E_TIMEOUT  = 2'b11;

    logic [2:0]              r_state;
    logic [TW-1:0]           r_tmo;
    logic [C_ADDR_WIDTH-1:0] r_addr;
    logic [C_DATA_WIDTH-1:0] r_wdata;
    logic [C_DATA_WIDTH-1:0] r_mask;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_arvalid;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic [1:0]              r_err_code;
    logic [7:0]              r_err_idx;
    logic [7:0]              r_tbl_idx;

    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_aw_left;
    logic       w_w_left;
    logic       w_tmo_hit;
    logic       w_rd_mismatch;
    logic       w_fail;
    logic [1:0] w_fail_code;

    assign w_aw_hs       = r_awvalid & M_AXI.AWREADY;
    assign w_w_hs        = r_wvalid & M_AXI.WREADY;
    // A channel is still outstanding after this edge only if its VALID is up and not accepted now.
    assign w_aw_left     = r_awvalid & ~M_AXI.AWREADY;
    assign w_w_left      = r_wvalid & ~M_AXI.WREADY;
    // The counter started at 0 on state entry, so this cycle is the C_TIMEOUT-th wait cycle.
    assign w_tmo_hit     = (r_tmo == TMO_LAST);
    assign w_rd_mismatch = |((M_AXI.RDATA ^ r_wdata) & r_mask);

    // Abort conditions. A handshake completing in the same cycle as the timeout wins.
    always_comb begin
        w_fail      = 1'b0;
        w_fail_code = 2'b00;
        case (r_state)
            S_WRITE: begin
                if ((w_aw_left || w_w_left) && w_tmo_hit) begin
                    w_fail      = 1'b1;
                    w_fail_code = E_TIMEOUT;
                end
            end
            S_BRESP: begin
                if (M_AXI.BVALID) begin
                    if (M_AXI.BRESP != 2'b00) begin
                        w_fail      = 1'b1;
                        w_fail_code = E_RESP;
                    end
                end else if (w_tmo_hit) begin
                    w_fail      = 1'b1;
                    w_fail_code = E_TIMEOUT;
                end
            end
            S_READ: begin
                if (!M_AXI.ARREADY && w_tmo_hit) begin
                    w_fail      = 1'b1;
                    w_fail_code = E_TIMEOUT;
                end
            end
            S_RDATA: begin
                if (M_AXI.RVALID) begin
                    if (M_AXI.RRESP != 2'b00) begin
                        w_fail      = 1'b1;
                        w_fail_code = E_RESP;
                    end else if (w_rd_mismatch) begin
                        w_fail      = 1'b1;
                        w_fail_code = E_MISMATCH;
                    end
                end else if (w_tmo_hit) begin
                    w_fail      = 1'b1;
                    w_fail_code = E_TIMEOUT;
                end
            end
            default: begin
                w_fail      = 1'b0;
                w_fail_code = 2'b00;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state    <= S_IDLE;
            r_tmo      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
            r_err_idx  <= 8'd0;
            r_tbl_idx  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= 2'b00;
                        r_err_idx  <= 8'd0;
                        r_tbl_idx  <= 8'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // tbl_* already answers r_tbl_idx, which was updated on the previous edge.
                    r_addr    <= C_BASE_ADDR + tbl_offset;
                    r_wdata   <= tbl_wdata;
                    r_mask    <= tbl_mask;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                    r_tmo     <= '0;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    if (!w_aw_left && !w_w_left) begin
                        r_tmo   <= '0;
                        r_state <= S_BRESP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_BRESP: begin
                    if (M_AXI.BVALID) begin
                        r_tmo <= '0;
                        if (C_VERIFY != 0) begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_READ;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_READ: begin
                    if (M_AXI.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_tmo     <= '0;
                        r_state   <= S_RDATA;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_RDATA: begin
                    if (M_AXI.RVALID) begin
                        r_tmo   <= '0;
                        r_state <= S_NEXT;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_NEXT: begin
                    // Completion is flagged here and the machine drops straight back to IDLE.
                    if (r_tbl_idx == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tbl_idx <= r_tbl_idx + 8'd1;
                        r_state   <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Any abort overrides the per-state updates above and releases the bus at once.
            if (w_fail) begin
                r_awvalid  <= 1'b0;
                r_wvalid   <= 1'b0;
                r_arvalid  <= 1'b0;
                r_busy     <= 1'b0;
                r_error    <= 1'b1;
                r_err_code <= w_fail_code;
                r_err_idx  <= r_tbl_idx;
                r_tmo      <= '0;
                r_state    <= S_IDLE;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_err_code;
    assign err_idx  = r_err_idx;
    assign tbl_idx  = r_tbl_idx;

    assign M_AXI.AWADDR  = r_addr;
    assign M_AXI.AWPROT  = 3'b000;
    assign M_AXI.AWVALID = r_awvalid;
    assign M_AXI.WDATA   = r_wdata;
    assign M_AXI.WSTRB   = '1;
    assign M_AXI.WVALID  = r_wvalid;
    assign M_AXI.BREADY  = (r_state == S_BRESP);
    assign M_AXI.ARADDR  = r_addr;
    assign M_AXI.ARPROT  = 3'b000;
    assign M_AXI.ARVALID = r_arvalid;
    assign M_AXI.RREADY  = (r_state == S_RDATA);

endmodule

// File: tb/tb_axi_i2s_cfg_sequencer.sv
// tb/tb_axi_i2s_cfg_sequencer.sv - scoreboard bench for axi_i2s_cfg_sequencer
module tb_axi_i2s_cfg_sequencer;
    localparam int          N    = 4;
    localparam int          TMO  = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [7:0]  err_idx, tbl_idx;
    logic [31:0] tbl_offset, tbl_wdata, tbl_mask;

    logic [31:0] tab_off [N];
    logic [31:0] tab_dat [N];
    logic [31:0] tab_msk [N];

    assign tbl_offset = tab_off[tbl_idx[1:0]];
    assign tbl_wdata  = tab_dat[tbl_idx[1:0]];
    assign tbl_mask   = tab_msk[tbl_idx[1:0]];

    axi_i2s_cfg_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi_i2s_cfg_sequencer #(
        .C_ADDR_WIDTH(32), .C_DATA_WIDTH(32), .C_NUM_ENTRIES(N),
        .C_BASE_ADDR(BASE), .C_VERIFY(1), .C_TIMEOUT(TMO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .err_idx(err_idx), .tbl_idx(tbl_idx),
        .tbl_offset(tbl_offset), .tbl_wdata(tbl_wdata), .tbl_mask(tbl_mask),
        .M_AXI(axi)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard queues: {done,error,err_code,err_idx} per run plus expected bus traffic.
    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [11:0] exp_res[$];

    // Slave behaviour knobs (per table entry).
    int          aw_dly[N], w_dly[N], b_dly[N], ar_dly[N], r_dly[N];
    int          bresp_err_idx = -1;
    int          corrupt_idx = -1;
    logic [31:0] corrupt_xor = 32'h0;
    bit          stuck = 1'b0;
    bit          clr_req = 1'b0;

    // Reference model: walk the table by the published rules and predict traffic and outcome.
    task automatic model_push();
        logic [31:0] a;
        logic [31:0] rb;
        if (stuck) begin
            exp_res.push_back({1'b0, 1'b1, 2'b11, 8'd0});
            return;
        end
        for (int i = 0; i < N; i++) begin
            a = BASE + tab_off[i];
            exp_aw.push_back(a);
            exp_w.push_back(tab_dat[i]);
            if (i == bresp_err_idx) begin
                exp_res.push_back({1'b0, 1'b1, 2'b01, 8'(i)});
                return;
            end
            exp_ar.push_back(a);
            rb = tab_dat[i] ^ ((i == corrupt_idx) ? corrupt_xor : 32'h0);
            if (((rb ^ tab_dat[i]) & tab_msk[i]) != 32'h0) begin
                exp_res.push_back({1'b0, 1'b1, 2'b10, 8'(i)});
                return;
            end
        end
        exp_res.push_back({1'b1, 1'b0, 2'b00, 8'd0});
    endtask

    // AXI4-Lite slave with memory, programmable wait states and fault injection.
    int          k_aw, k_w, k_b, k_ar, k_r, aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_pend;
    logic [31:0] s_awq[$], s_wq[$], s_arq[$];
    logic [31:0] mem [logic [31:0]];
    bit          b_hs, r_hs;

    task automatic slave_clear();
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0;
        axi.ARREADY = 0; axi.RVALID = 0; axi.RRESP = 0; axi.RDATA = 0;
        k_aw = 0; k_w = 0; k_b = 0; k_ar = 0; k_r = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; b_pend = 0;
        s_awq.delete(); s_wq.delete(); s_arq.delete(); mem.delete();
        b_hs = 0; r_hs = 0;
    endtask

    initial begin
        logic [31:0] a, d;
        slave_clear();
        forever begin
            @(negedge ACLK);
            if (ARESET || clr_req) begin
                slave_clear();
                clr_req = 0;
                continue;
            end
            if (b_hs) begin axi.BVALID = 0; b_hs = 0; end
            if (r_hs) begin axi.RVALID = 0; r_hs = 0; end
            while (s_awq.size() > 0 && s_wq.size() > 0) begin
                a = s_awq.pop_front();
                d = s_wq.pop_front();
                mem[a] = d;
                b_pend++;
            end
            if (!axi.BVALID && b_pend > 0) begin
                if (b_cnt >= ((k_b < N) ? b_dly[k_b] : 0)) begin
                    axi.BVALID = 1;
                    axi.BRESP  = (k_b == bresp_err_idx) ? 2'b10 : 2'b00;
                    b_pend--; k_b++; b_cnt = 0;
                end else b_cnt++;
            end
            if (axi.BVALID && axi.BREADY) b_hs = 1;
            axi.AWREADY = 0;
            if (axi.AWVALID && !stuck) begin
                if (aw_cnt >= ((k_aw < N) ? aw_dly[k_aw] : 0)) begin
                    axi.AWREADY = 1; s_awq.push_back(axi.AWADDR); aw_cnt = 0; k_aw++;
                end else aw_cnt++;
            end
            axi.WREADY = 0;
            if (axi.WVALID && !stuck) begin
                if (w_cnt >= ((k_w < N) ? w_dly[k_w] : 0)) begin
                    axi.WREADY = 1; s_wq.push_back(axi.WDATA); w_cnt = 0; k_w++;
                end else w_cnt++;
            end
            if (!axi.RVALID && s_arq.size() > 0) begin
                if (r_cnt >= ((k_r < N) ? r_dly[k_r] : 0)) begin
                    a = s_arq.pop_front();
                    axi.RVALID = 1;
                    axi.RRESP  = 2'b00;
                    axi.RDATA  = (mem.exists(a) ? mem[a] : 32'h0) ^ ((k_r == corrupt_idx) ? corrupt_xor : 32'h0);
                    k_r++; r_cnt = 0;
                end else r_cnt++;
            end
            if (axi.RVALID && axi.RREADY) r_hs = 1;
            axi.ARREADY = 0;
            if (axi.ARVALID) begin
                if (ar_cnt >= ((k_ar < N) ? ar_dly[k_ar] : 0)) begin
                    axi.ARREADY = 1; s_arq.push_back(axi.ARADDR); ar_cnt = 0; k_ar++;
                end else ar_cnt++;
            end
        end
    end

    // Monitor: samples shortly after the slave has settled, ahead of the next rising edge.
    initial begin
        bit          prev_busy, prev_aw_wait, prev_w_wait;
        logic [31:0] prev_awaddr, prev_wdata;
        prev_busy = 0; prev_aw_wait = 0; prev_w_wait = 0; prev_awaddr = 0; prev_wdata = 0;
        forever begin
            @(negedge ACLK);
            #2;
            if (ARESET) begin
                prev_busy = 0; prev_aw_wait = 0; prev_w_wait = 0;
                continue;
            end
            if (prev_aw_wait && !error) begin
                chk("awvalid_hold", axi.AWVALID, 1);
                chk("awaddr_hold", axi.AWADDR, prev_awaddr);
            end
            if (prev_w_wait && !error) begin
                chk("wvalid_hold", axi.WVALID, 1);
                chk("wdata_hold", axi.WDATA, prev_wdata);
            end
            if (axi.AWVALID && axi.AWREADY) begin
                if (exp_aw.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL aw_unexpected: got addr %0h expected no write", axi.AWADDR);
                end else chk("aw_addr", {29'd0, axi.AWPROT, axi.AWADDR}, {32'd0, exp_aw.pop_front()});
            end
            if (axi.WVALID && axi.WREADY) begin
                if (exp_w.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL w_unexpected: got data %0h expected no write", axi.WDATA);
                end else chk("w_data", {28'd0, axi.WSTRB, axi.WDATA}, {28'd0, 4'hF, exp_w.pop_front()});
            end
            if (axi.ARVALID && axi.ARREADY) begin
                if (exp_ar.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL ar_unexpected: got addr %0h expected no read", axi.ARADDR);
                end else chk("ar_addr", {29'd0, axi.ARPROT, axi.ARADDR}, {32'd0, exp_ar.pop_front()});
            end
            prev_aw_wait = axi.AWVALID && !axi.AWREADY;
            prev_awaddr  = axi.AWADDR;
            prev_w_wait  = axi.WVALID && !axi.WREADY;
            prev_wdata   = axi.WDATA;
            if (prev_busy && !busy) begin
                if (exp_res.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL result_unexpected: got %0h expected no completion", {done, error, err_code, err_idx});
                end else chk("result", {done, error, err_code, err_idx}, exp_res.pop_front());
                chk("aw_leftover", exp_aw.size(), 0);
                chk("w_leftover", exp_w.size(), 0);
                chk("ar_leftover", exp_ar.size(), 0);
            end
            prev_busy = busy;
        end
    end

    task automatic run(input int extra_start, output int lat, output int awhi);
        int cyc;
        bit got;
        model_push();
        clr_req = 1;
        @(negedge ACLK);
        start = 1;
        cyc = 0; got = 0; awhi = 0; lat = -1;
        while (cyc < 2000) begin
            @(negedge ACLK);
            cyc++;
            if (cyc == 1) start = 0;
            if (extra_start > 0 && cyc == extra_start) start = 1;
            if (extra_start > 0 && cyc == extra_start + 1) start = 0;
            if (axi.AWVALID) awhi++;
            if (cyc > 1 && !busy) begin got = 1; break; end
        end
        lat = cyc - 1;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL run_bound: got busy %0d after %0d cycles expected idle", busy, cyc);
        end
        repeat (3) @(negedge ACLK);
        if (!got) begin
            ARESET = 1;
            exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
            repeat (2) @(negedge ACLK);
            ARESET = 0;
        end
    endtask

    task automatic set_default_table();
        tab_off[0] = 32'h0; tab_off[1] = 32'h4; tab_off[2] = 32'h8; tab_off[3] = 32'hC;
        tab_dat[0] = 32'h0101FFFF; tab_dat[1] = 32'habcd0001;
        tab_dat[2] = 32'hdead0011; tab_dat[3] = 32'hbeef0011;
        for (int i = 0; i < N; i++) begin
            tab_msk[i] = 32'hFFFFFFFF;
            aw_dly[i] = 0; w_dly[i] = 0; b_dly[i] = 0; ar_dly[i] = 0; r_dly[i] = 0;
        end
        bresp_err_idx = -1; corrupt_idx = -1; corrupt_xor = 0; stuck = 0;
    endtask

    initial begin
        int lat, awhi, f;
        set_default_table();
        ARESET = 1;
        repeat (3) @(negedge ACLK);
        chk("reset_status", {busy, done, error, err_code, err_idx, tbl_idx, axi.AWVALID,
                             axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}, 0);
        chk("reset_addr", {axi.AWADDR, axi.ARADDR}, 0);
        ARESET = 0;
        repeat (2) @(negedge ACLK);

        run(0, lat, awhi);
        chk("latency_zero_wait", lat, 24);

        aw_dly[1] = 3;
        run(0, lat, awhi);
        aw_dly[1] = 0;

        bresp_err_idx = 2;
        run(0, lat, awhi);
        bresp_err_idx = -1;

        corrupt_idx = 2; corrupt_xor = 32'h1;
        run(0, lat, awhi);
        tab_msk[2] = 32'hFFFFFFF0;
        run(0, lat, awhi);
        set_default_table();

        stuck = 1;
        run(0, lat, awhi);
        chk("timeout_awvalid_cycles", awhi, TMO);
        stuck = 0;

        // Reset in the middle of a write, then a full rerun.
        aw_dly[0] = 10;
        model_push();
        clr_req = 1;
        @(negedge ACLK); start = 1;
        @(negedge ACLK); start = 0;
        for (int i = 0; i < 20 && !axi.AWVALID; i++) @(negedge ACLK);
        chk("midreset_in_write", axi.AWVALID, 1);
        #1 ARESET = 1;
        #1;
        chk("midreset_status", {busy, done, error, err_code, err_idx, tbl_idx, axi.AWVALID,
                                axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}, 0);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
        repeat (2) @(negedge ACLK);
        ARESET = 0;
        aw_dly[0] = 0;
        run(0, lat, awhi);

        // Start pulse while busy must not restart the walk.
        run(6, lat, awhi);
        chk("busy_start_latency", lat, 24);

        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N; i++) begin
                tab_off[i] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                tab_dat[i] = $urandom;
                tab_msk[i] = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : $urandom;
                aw_dly[i] = $urandom_range(0, 4); w_dly[i] = $urandom_range(0, 4);
                b_dly[i] = $urandom_range(0, 4); ar_dly[i] = $urandom_range(0, 4);
                r_dly[i] = $urandom_range(0, 4);
            end
            bresp_err_idx = -1; corrupt_idx = -1; corrupt_xor = 0;
            f = $urandom_range(0, 3);
            if (f == 0) bresp_err_idx = $urandom_range(0, N - 1);
            if (f == 1) begin
                corrupt_idx = $urandom_range(0, N - 1);
                corrupt_xor = 32'h1 << $urandom_range(0, 31);
            end
            run(0, lat, awhi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
